pwm_capture: RTL



---
 rtl/pwm_capture.sv | 135 +++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: samples an external PWM input and reports its duty and period in prescaled steps.
// Define PWM_CAP_FILTER_EN to insert a 3-sample glitch filter after the synchroniser.
module pwm_capture #(
    parameter int TICK_DIV      = 1000,
    parameter int TIMEOUT_STEPS = 200
) (
    input  logic       clk,
    input  logic       rst_i,
    input  logic       pwm_i,
    output logic [6:0] duty_o,
    output logic [7:0] period_o,
    output logic       valid_o,
    output logic       stuck_o
);

    localparam int              PW           = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST   = PW'(TICK_DIV - 1);
    localparam logic [7:0]      TIMEOUT_LAST = 8'(TIMEOUT_STEPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        MEAS,
        STUCK
    } state_t;

    state_t        r_state;
    logic          r_sync1;
    logic          r_pwm_s;
    logic          r_lvl;
    logic [PW-1:0] r_presc;
    logic [7:0]    r_per_cnt;
    logic [7:0]    r_hi_cnt;

    logic          w_lvl;
    logic          w_rise;
    logic          w_tick;
    logic [7:0]    w_per_inc;
    logic [7:0]    w_hi_inc;
    logic [7:0]    w_restart;

    // NOTE: every clocked register uses <= so all flops sample pre-edge values together.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_sync1 <= 1'b0;
            r_pwm_s <= 1'b0;
        end else begin
            r_sync1 <= pwm_i;
            r_pwm_s <= r_sync1;
        end
    end

`ifdef PWM_CAP_FILTER_EN
    logic [1:0] r_hist;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_hist <= 2'b00;
        end else begin
            r_hist <= {r_hist[0], r_pwm_s};
        end
    end

    // Level follows pwm_s only once the current and two previous samples agree.
    assign w_lvl = ((r_pwm_s == r_hist[0]) && (r_pwm_s == r_hist[1])) ? r_pwm_s : r_lvl;
`else
    assign w_lvl = r_pwm_s;
`endif

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_lvl <= 1'b0;
        end else begin
            r_lvl <= w_lvl;
        end
    end

    assign w_rise = w_lvl & ~r_lvl;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    assign w_tick    = (r_presc == PRESC_LAST);
    assign w_per_inc = (r_per_cnt == 8'hFF) ? r_per_cnt : r_per_cnt + 8'd1;
    assign w_hi_inc  = (r_hi_cnt == 8'hFF) ? r_hi_cnt : r_hi_cnt + 8'd1;
    // A tick on the rising-edge cycle already belongs to the new period.
    assign w_restart = {7'd0, w_tick};

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_per_cnt <= 8'd0;
            r_hi_cnt  <= 8'd0;
            duty_o    <= 7'd0;
            period_o  <= 8'd0;
            valid_o   <= 1'b0;
            stuck_o   <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (w_rise) begin
                if (r_state == MEAS) begin
                    duty_o   <= (r_hi_cnt > 8'd127) ? 7'd127 : r_hi_cnt[6:0];
                    period_o <= r_per_cnt;
                    valid_o  <= 1'b1;
                    stuck_o  <= 1'b0;
                end
                r_state   <= MEAS;
                r_per_cnt <= w_restart;
                r_hi_cnt  <= w_restart;
            end else if (w_tick && (r_state != STUCK)) begin
                if (r_per_cnt == TIMEOUT_LAST) begin
                    duty_o    <= w_lvl ? 7'd100 : 7'd0;
                    period_o  <= 8'd0;
                    valid_o   <= 1'b1;
                    stuck_o   <= 1'b1;
                    r_per_cnt <= 8'd0;
                    r_hi_cnt  <= 8'd0;
                    r_state   <= STUCK;
                end else begin
                    r_per_cnt <= w_per_inc;
                    if (w_lvl) begin
                        r_hi_cnt <= w_hi_inc;
                    end
                end
            end
        end
    end

endmodule
